mtm_alu_resp_scheduler: RTL and testbench
=========================================

# mtm_alu_resp_scheduler

Response scheduler between the ALU result path and `mtm_Alu_serializer`. The serializer has no ready/ack signal: it samples `C`/`CTL_out` whenever it is idle and then runs blind for a fixed frame count. This block buffers ALU results in a small in-order FIFO and drives exactly one result per serializer slot. It holds the serializer's inputs at the idle code for the rest of the slot, so no result is lost or double-sent.

## Interface
- `DEPTH`, 4 — FIFO entries; power of 2, ≥2.
- `DATA_SLOT`, 56 — issue-to-issue cycles for a data response (4 data frames + 1 CTL frame of 11 bits, plus 1 idle-sample cycle).
- `ERR_SLOT`, 12 — issue-to-issue cycles for an error response (1 CTL frame plus 1 idle-sample cycle).
- `IDLE_CTL`, 8'hFF — code driven on `ser_ctl` when nothing is issued; bit7=1 and not an error code.
- `clk`  in  1  clock, posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `res_valid`  in  1  ALU result valid.
- `res_ready`  out  1  block can accept; `res_ready = (level != DEPTH)`, combinational from registered level.
- `res_c`  in  32  result word.
- `res_ctl`  in  8  result CTL byte.
- `ser_c`  out  32  to serializer `C`, registered.
- `ser_ctl`  out  8  to serializer `CTL_out`, registered.
- `busy`  out  1  `state != IDLE || level != 0`.
- `drop`  out  1  one-cycle pulse: illegal CTL consumed and discarded.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Accept:** handshake when `res_valid && res_ready` at a clock edge.
- **Legal CTL values:**
  - bit7=0: data type, uses `DATA_SLOT`.
  - 8'h93, 8'hC9 or 8'hA5: error type, uses `ERR_SLOT`.
  - Legal entries are pushed as {c, ctl, type}.
- **Illegal CTL** (bit7=1, not an error code): consumed, not stored, `drop`=1 in the following cycle.
- **Full FIFO:** `res_ready`=0, even if a pop occurs in the same cycle. No push-through.
- **FSM states:**
  - IDLE: `ser_ctl`=`IDLE_CTL`. If level≠0 at the edge, load the head into `ser_c`/`ser_ctl`, pop, load slot counter `cnt` with slot-2, and go to ISSUE.
  - ISSUE: lasts 1 cycle; the head is visible on the outputs. At the next edge set `ser_ctl`←`IDLE_CTL`, set `ser_c`←0, and go to WAIT. If slot-2=0, go to IDLE instead.
  - WAIT: decrement `cnt` each cycle. Exit to IDLE after the edge where `cnt`=1, so WAIT lasts slot-2 cycles.
  - Slot = ISSUE(1) + WAIT(slot-2) + IDLE(1) = `DATA_SLOT` or `ERR_SLOT`.
- **Ordering:** strict FIFO order. Error responses never bypass data responses.
- **Counters:** FIFO read/write pointers wrap modulo `DEPTH`. `cnt` is 6 bits minimum and sized from max(`DATA_SLOT`,`ERR_SLOT`).
- **Simultaneous push and pop:** in the same cycle, level is unchanged and both pointers advance.

## Timing
- **Reset values:** `ser_c`=0, `ser_ctl`=`IDLE_CTL`, `drop`=0, `level`=0, `busy`=0, `res_ready`=1, state IDLE, pointers 0.
- **Latency:** a result accepted at edge e into an empty FIFO while in IDLE appears on `ser_*` in the cycle after edge e+1, i.e. ISSUE is the 2nd cycle after acceptance.
- **Back-to-back issues:** with the FIFO non-empty, ISSUE cycles are exactly `DATA_SLOT` or `ERR_SLOT` apart, according to the type issued first.
- **Reset mid-operation** (any state): everything returns to reset values at that edge and FIFO contents are discarded. The serializer shares `rst_n`, so it aborts its frame in the same edge.
- **`drop` and the FSM:** `drop` never stalls the FSM and never changes `level`.

## Test plan
- **Single data response:** `res_c`=32'h12345678, `res_ctl`=8'h1A accepted at cycle 0.
  - `ser_c`/`ser_ctl`=12345678/1A during cycle 2 only, then 0/FF.
  - `sout` carries 5 frames: `0 0 <byte> 1` ×4, then `0 1 00011010 1`.
  - `busy` falls at cycle 57.
- **Three data results back-to-back:** ISSUE at cycles 2, 58, 114, in order. Each word is serialized once.
- **Mixed types:** 8'hC9 error then a data result. ISSUE at cycles 2 and 14. `sout` error frame is `0 1 11001001 1`.
- **Backpressure:** `res_valid` held for 6 results. After the first pop, 4 more are accepted and `level`=4. `res_ready`=0 until the next ISSUE pops, then the 6th is accepted. No entry is lost or duplicated.
- **Illegal CTL:** `res_ctl`=8'h80 accepted. `drop`=1 for 1 cycle, `level` stays 0, no ISSUE, `ser_ctl` stays FF.
- **Reset during WAIT:** reset with 2 entries queued. Outputs return to reset values next cycle, `level`=0, `sout`=1, and the queued entries are never issued.

Source files
------------

// File: rtl/mtm_alu_resp_scheduler.sv
// Response scheduler: buffers ALU results in an in-order FIFO and hands exactly
// one result to the serializer per serializer slot. The serializer has no
// ready signal, so the slot length is enforced here by a countdown.
module mtm_alu_resp_scheduler #(
    parameter int          DEPTH     = 4,
    parameter int          DATA_SLOT = 56,
    parameter int          ERR_SLOT  = 12,
    parameter logic [7:0]  IDLE_CTL  = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [31:0]              res_c,
    input  logic [7:0]               res_ctl,
    output logic [31:0]              ser_c,
    output logic [7:0]               ser_ctl,
    output logic                     busy,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int MAX_SLOT = (DATA_SLOT > ERR_SLOT) ? DATA_SLOT : ERR_SLOT;
    localparam int CNT_RAW  = $clog2(MAX_SLOT);
    localparam int CNT_W    = (CNT_RAW < 6) ? 6 : CNT_RAW;

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  ctl;
        logic        is_err;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [31:0]        ser_c_nxt;
    logic [7:0]         ser_ctl_nxt;
    logic               is_err_code;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;
    entry_t             head;

    // Ready depends only on the registered level, so a same-cycle pop never
    // opens a full FIFO (no push-through).
    assign res_ready   = (level != LVL_W'(DEPTH));
    assign busy        = (state != ST_IDLE) || (level != '0);
    assign is_err_code = (res_ctl == 8'h93) || (res_ctl == 8'hC9) || (res_ctl == 8'hA5);
    assign legal       = !res_ctl[7] || is_err_code;
    assign accept      = res_valid && res_ready;
    assign push        = accept && legal;
    assign head        = mem[rd_ptr];

    // FIFO storage write.
    // NOTE: the storage array carries no reset; validity is tracked by level
    // and the pointers, so clearing the payload would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{c: res_c, ctl: res_ctl, is_err: is_err_code};
        end
    end

    // Pointers, occupancy and the illegal-CTL drop pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= accept && !legal;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM state, slot counter and serializer output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ser_c   <= '0;
            ser_ctl <= IDLE_CTL;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ser_c   <= ser_c_nxt;
            ser_ctl <= ser_ctl_nxt;
        end
    end

    // Next-state logic: issue the head from IDLE, hold idle code for the slot.
    // NOTE: every output of this block is defaulted first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ser_c_nxt   = ser_c;
        ser_ctl_nxt = ser_ctl;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                ser_c_nxt   = '0;
                ser_ctl_nxt = IDLE_CTL;
                if (level != '0) begin
                    pop         = 1'b1;
                    ser_c_nxt   = head.c;
                    ser_ctl_nxt = head.ctl;
                    cnt_nxt     = head.is_err ? CNT_W'(ERR_SLOT - 2)
                                              : CNT_W'(DATA_SLOT - 2);
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ser_c_nxt   = '0;
                ser_ctl_nxt = IDLE_CTL;
                state_nxt   = (cnt == '0) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            end
            default: begin
                ser_c_nxt   = '0;
                ser_ctl_nxt = IDLE_CTL;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mtm_alu_resp_scheduler.sv
// Directed bench for mtm_alu_resp_scheduler: single issue, back-to-back,
// mixed types, backpressure, illegal CTL and reset mid-slot.
module tb_mtm_alu_resp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_c = '0;
    logic [7:0]  res_ctl = '0;
    logic [31:0] ser_c;
    logic [7:0]  ser_ctl;
    logic        busy;
    logic        drop;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    int          q_cyc[$];
    logic [31:0] q_c[$];
    logic [7:0]  q_ctl[$];

    mtm_alu_resp_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c),
        .res_ctl   (res_ctl),
        .ser_c     (ser_c),
        .ser_ctl   (ser_ctl),
        .busy      (busy),
        .drop      (drop),
        .level     (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which a result is presented to the serializer.
    always @(negedge clk) begin
        if (mon_en && ser_ctl !== 8'hFF) begin
            q_cyc.push_back(cyc);
            q_c.push_back(ser_c);
            q_ctl.push_back(ser_ctl);
        end
    end

    task automatic clear_q();
        q_cyc.delete();
        q_c.delete();
        q_ctl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int base, input int bound, output int rel);
        rel = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                rel = cyc - base;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ser_c !== 32'h0) begin errors++; $display("FAIL reset_ser_c: got %h want 00000000", ser_c); end
        checks++; if (ser_ctl !== 8'hFF) begin errors++; $display("FAIL reset_ser_ctl: got %h want ff", ser_ctl); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", res_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        int base;
        int rel;
        do_reset();
        clear_q();
        @(negedge clk);
        res_valid = 1'b1; res_c = 32'h12345678; res_ctl = 8'h1A; base = cyc;
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_c1: got %0d want 1", level); end
        checks++; if (ser_ctl !== 8'hFF) begin errors++; $display("FAIL single_early_issue: got %h want ff", ser_ctl); end
        @(negedge clk);
        checks++; if (ser_c !== 32'h12345678) begin errors++; $display("FAIL single_issue_c: got %h want 12345678", ser_c); end
        checks++; if (ser_ctl !== 8'h1A) begin errors++; $display("FAIL single_issue_ctl: got %h want 1a", ser_ctl); end
        @(negedge clk);
        checks++; if (ser_c !== 32'h0) begin errors++; $display("FAIL single_after_c: got %h want 00000000", ser_c); end
        checks++; if (ser_ctl !== 8'hFF) begin errors++; $display("FAIL single_after_ctl: got %h want ff", ser_ctl); end
        wait_idle(base, 200, rel);
        checks++; if (rel !== 57) begin errors++; $display("FAIL single_busy_fall: got %0d want 57", rel); end
        checks++; if (q_cyc.size() !== 1) begin errors++; $display("FAIL single_issue_count: got %0d want 1", q_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        int base;
        int rel;
        logic [31:0] exp_c [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        logic [7:0]  exp_ctl [3] = '{8'h01, 8'h02, 8'h03};
        int          exp_cyc [3] = '{2, 58, 114};
        do_reset();
        clear_q();
        @(negedge clk);
        base = cyc;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            res_valid = 1'b1; res_c = exp_c[i]; res_ctl = exp_ctl[i];
        end
        @(negedge clk);
        res_valid = 1'b0;
        wait_idle(base, 400, rel);
        checks++; if (q_cyc.size() !== 3) begin errors++; $display("FAIL b2b_issue_count: got %0d want 3", q_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                errors++; $display("FAIL b2b_missing_%0d: got none want %h/%h", i, exp_c[i], exp_ctl[i]);
            end else if (q_cyc[i] - base !== exp_cyc[i] || q_c[i] !== exp_c[i] || q_ctl[i] !== exp_ctl[i]) begin
                errors++; $display("FAIL b2b_issue_%0d: got cyc %0d %h/%h want cyc %0d %h/%h",
                    i, q_cyc[i] - base, q_c[i], q_ctl[i], exp_cyc[i], exp_c[i], exp_ctl[i]);
            end
        end
    endtask

    task automatic test_mixed();
        int base;
        int rel;
        do_reset();
        clear_q();
        @(negedge clk);
        res_valid = 1'b1; res_c = 32'hE000_00C9; res_ctl = 8'hC9; base = cyc;
        @(negedge clk);
        res_c = 32'h0BAD_F00D; res_ctl = 8'h05;
        @(negedge clk);
        res_valid = 1'b0;
        wait_idle(base, 200, rel);
        checks++; if (rel !== 69) begin errors++; $display("FAIL mixed_busy_fall: got %0d want 69", rel); end
        checks++; if (q_cyc.size() !== 2) begin errors++; $display("FAIL mixed_issue_count: got %0d want 2", q_cyc.size()); end
        if (q_cyc.size() >= 2) begin
            checks++;
            if (q_cyc[0] - base !== 2 || q_c[0] !== 32'hE000_00C9 || q_ctl[0] !== 8'hC9) begin
                errors++; $display("FAIL mixed_err_issue: got cyc %0d %h/%h want cyc 2 e00000c9/c9", q_cyc[0] - base, q_c[0], q_ctl[0]);
            end
            checks++;
            if (q_cyc[1] - base !== 14 || q_c[1] !== 32'h0BAD_F00D || q_ctl[1] !== 8'h05) begin
                errors++; $display("FAIL mixed_data_issue: got cyc %0d %h/%h want cyc 14 0badf00d/05", q_cyc[1] - base, q_c[1], q_ctl[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int rel;
        int n;
        int full_rel = -1;
        logic [2:0] full_level = '0;
        int acc [6];
        int exp_acc [6] = '{0, 1, 2, 3, 4, 58};
        do_reset();
        clear_q();
        @(negedge clk);
        base = cyc;
        n = 0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            if (k > 0) @(negedge clk);
            res_valid = 1'b1; res_c = 32'hB000_0000 + 32'(n); res_ctl = 8'(n + 1);
            if (res_ready) begin
                acc[n] = cyc - base;
                n++;
            end else if (full_rel < 0) begin
                full_rel = cyc - base;
                full_level = level;
            end
        end
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (full_rel !== 5) begin errors++; $display("FAIL bp_first_stall: got %0d want 5", full_rel); end
        checks++; if (full_level !== 3'd4) begin errors++; $display("FAIL bp_full_level: got %0d want 4", full_level); end
        checks++; if (n !== 6) begin errors++; $display("FAIL bp_accept_count: got %0d want 6", n); end
        if (n == 6) begin
            checks++; if (acc[5] !== exp_acc[5]) begin errors++; $display("FAIL bp_sixth_accept: got %0d want %0d", acc[5], exp_acc[5]); end
        end
        wait_idle(base, 600, rel);
        checks++; if (q_cyc.size() !== 6) begin errors++; $display("FAIL bp_issue_count: got %0d want 6", q_cyc.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= q_cyc.size()) begin
                errors++; $display("FAIL bp_missing_%0d: got none want %h", i, 32'hB000_0000 + 32'(i));
            end else if (q_cyc[i] - base !== 2 + 56 * i || q_c[i] !== 32'hB000_0000 + 32'(i) || q_ctl[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL bp_issue_%0d: got cyc %0d %h/%h want cyc %0d %h/%h",
                    i, q_cyc[i] - base, q_c[i], q_ctl[i], 2 + 56 * i, 32'hB000_0000 + 32'(i), 8'(i + 1));
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        clear_q();
        @(negedge clk);
        res_valid = 1'b1; res_c = 32'hCAFE_0080; res_ctl = 8'h80;
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL illegal_drop: got %b want 1", drop); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL illegal_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL illegal_drop_pulse: got %b want 0", drop); end
        repeat (10) @(negedge clk);
        checks++; if (q_cyc.size() !== 0) begin errors++; $display("FAIL illegal_issued: got %0d want 0", q_cyc.size()); end
    endtask

    task automatic test_reset_wait();
        int base;
        do_reset();
        clear_q();
        @(negedge clk);
        base = cyc;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            res_valid = 1'b1; res_c = 32'hA000_0000 + 32'(i); res_ctl = 8'(8'h10 + i);
        end
        @(negedge clk);
        res_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL rw_level_before: got %0d want 2", level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ser_c !== 32'h0 || ser_ctl !== 8'hFF) begin errors++; $display("FAIL rw_ser: got %h/%h want 00000000/ff", ser_c, ser_ctl); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rw_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL rw_busy_ready: got %b/%b want 0/1", busy, res_ready); end
        repeat (150) @(negedge clk);
        checks++; if (q_cyc.size() !== 1) begin errors++; $display("FAIL rw_issue_count: got %0d want 1", q_cyc.size()); end
        if (q_cyc.size() >= 1) begin
            checks++; if (q_c[0] !== 32'hA000_0000 || q_cyc[0] - base !== 2) begin
                errors++; $display("FAIL rw_first_issue: got cyc %0d %h want cyc 2 a0000000", q_cyc[0] - base, q_c[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mixed();
        test_backpressure();
        test_illegal();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
